// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: funct3 widths, MMIO offsets, lane count.
package dmem_pkg;

    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } op_e;

    localparam logic [15:0] MMIO_LED_OFS = 16'h0000;
    localparam logic [15:0] MMIO_CNT_OFS = 16'h0004;

    localparam int LANES = 4;

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of a RAM word and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  ofs,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{ofs, 3'b000} +: 8];
        half_sel = ofs[1] ? word[31:16] : word[15:0];
        case (op)
            OP_B:    data = {{24{byte_sel[7]}}, byte_sel};
            OP_BU:   data = {24'b0, byte_sel};
            OP_H:    data = {{16{half_sel[15]}}, half_sel};
            OP_HU:   data = {16'b0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM with 1-cycle registered loads.
// Define DMEM_MMIO_EN to decode the LED register / cycle counter window.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 15,
    parameter logic [15:0] MMIO_HI    = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  op,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err,
    output logic [15:0] led
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [LANES-1:0][7:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0]  idx;
    logic                   op_ok, aligned, in_mmio, legal;
    logic                   ram_we, ld_req;
    logic [LANES-1:0]       be;
    logic [LANES-1:0][7:0]  wlanes;
    logic [31:0]            ram_ld, mmio_ld, ld_val;

    assign idx = addr[ADDR_WIDTH+1:2];

    always_comb begin
        op_ok   = 1'b0;
        aligned = 1'b0;
        case (op)
            OP_B, OP_BU: begin op_ok = 1'b1; aligned = 1'b1;               end
            OP_H, OP_HU: begin op_ok = 1'b1; aligned = ~addr[0];           end
            OP_W:        begin op_ok = 1'b1; aligned = (addr[1:0] == 2'b00); end
            default: ;
        endcase
    end

`ifdef DMEM_MMIO_EN
    assign in_mmio = (addr[31:16] == MMIO_HI);
`else
    assign in_mmio = 1'b0;
`endif

    // MMIO registers are word-only; anything narrower is treated like misalignment.
    assign legal  = op_ok && aligned && (!in_mmio || op == OP_W);
    assign ram_we = we && legal && !in_mmio;
    assign ld_req = rd && !we;

    always_comb begin
        be     = '0;
        wlanes = wdata;
        case (op)
            OP_B, OP_BU: begin
                be[addr[1:0]] = 1'b1;
                wlanes        = {4{wdata[7:0]}};
            end
            OP_H, OP_HU: begin
                be[{addr[1], 1'b0}] = 1'b1;
                be[{addr[1], 1'b1}] = 1'b1;
                wlanes              = {2{wdata[15:0]}};
            end
            default: be = '1;
        endcase
    end

    // RAM is not cleared, but sits behind the reset so a store on a reset edge never lands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
        end else if (ram_we) begin
            for (int i = 0; i < LANES; i++)
                if (be[i]) mem[idx][i] <= wlanes[i];
        end
    end

    dmem_load_align u_align (
        .word (mem[idx]),
        .ofs  (addr[1:0]),
        .op   (op),
        .data (ram_ld)
    );

`ifdef DMEM_MMIO_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led       <= '0;
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (we && legal && in_mmio && addr[15:0] == MMIO_LED_OFS)
                led <= wdata[15:0];
        end
    end

    always_comb begin
        case (addr[15:0])
            MMIO_LED_OFS: mmio_ld = {16'b0, led};
            MMIO_CNT_OFS: mmio_ld = cycle_cnt;
            default:      mmio_ld = '0;
        endcase
    end
`else
    assign led     = '0;
    assign mmio_ld = '0;
`endif

    assign ld_val = in_mmio ? mmio_ld : ram_ld;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= ld_req;
            err    <= (we || rd) && !legal;
            if (ld_req) rdata <= legal ? ld_val : '0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr, wdata[31:16], MMIO_HI};

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a byte-addressed reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [2:0]  op = '0;
    logic        we = 1'b0, rd = 1'b0;
    logic [31:0] rdata;
    logic        rvalid, err;
    logic [15:0] led;

    dmem_responder dut (
        .clock(clk), .reset(reset), .addr(addr), .wdata(wdata), .op(op),
        .we(we), .rd(rd), .rdata(rdata), .rvalid(rvalid), .err(err), .led(led)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mm [int];
    logic [31:0] rd_e = '0;
    logic        rv_e = 1'b0, err_e = 1'b0;
    logic [15:0] led_m = '0;
    logic [31:0] edges = '0;

    always @(posedge clk or negedge reset)
        if (!reset) edges <= '0;
        else        edges <= edges + 32'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] o);
        case (o)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit in_win(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
        return a[31:16] == 16'hFFFF;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit legal_m(input logic [2:0] o, input logic [31:0] a);
        int s = sz(o);
        if (s == 0) return 1'b0;
        if ((a % s) != 0) return 1'b0;
        if (in_win(a) && o != 3'b010) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ba(input logic [31:0] a);
        return int'(a & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] load_m(input logic [2:0] o, input logic [31:0] a);
        logic [31:0] v = '0;
        int s = sz(o);
        if (in_win(a)) begin
            if (a[15:0] == 16'h0000) return {16'b0, led_m};
            if (a[15:0] == 16'h0004) return edges;
            return '0;
        end
        for (int i = 0; i < s; i++) v = v | (32'(mm[ba(a) + i]) << (8 * i));
        if (!o[2] && s < 4 && v[8*s-1]) v = v | ~((32'h1 << (8 * s)) - 32'h1);
        return v;
    endfunction

    task automatic store_m(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        if (in_win(a)) begin
            if (a[15:0] == 16'h0000) led_m = d[15:0];
        end else begin
            for (int i = 0; i < sz(o); i++) mm[ba(a) + i] = d[8*i +: 8];
        end
    endtask

    // One request cycle: drive, let the DUT sample it, then check the registered response.
    task automatic acc(input bit w, input bit r, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] d, input string tag);
        bit ok = legal_m(o, a);
        we = w; rd = r; op = o; addr = a; wdata = d;
        err_e = (w || r) && !ok;
        rv_e  = r && !w;
        if (r && !w) rd_e = ok ? load_m(o, a) : '0;
        if (w && ok) store_m(o, a, d);
        @(posedge clk); #1;
        we = 1'b0; rd = 1'b0;
        chk({tag, ".rvalid"}, 32'(rvalid), 32'(rv_e));
        chk({tag, ".err"},    32'(err),    32'(err_e));
        chk({tag, ".rdata"},  rdata,       rd_e);
        chk({tag, ".led"},    32'(led),    32'(led_m));
    endtask

    task automatic idle();
        acc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, "idle");
    endtask

    initial begin
        logic [31:0] c1, c2;
        #2;
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.rvalid", 32'(rvalid), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        chk("rst.led", 32'(led), 32'h0);
        #5 reset = 1'b1;

        acc(1, 0, 3'b010, 32'h10, 32'h8000_00FF, "sw10");
        acc(0, 1, 3'b000, 32'h10, 32'h0, "lb10");
        chk("lb10.const", rdata, 32'hFFFF_FFFF);
        acc(0, 1, 3'b100, 32'h13, 32'h0, "lbu13");
        chk("lbu13.const", rdata, 32'h0000_0080);
        acc(0, 1, 3'b001, 32'h12, 32'h0, "lh12");
        chk("lh12.const", rdata, 32'hFFFF_8000);
        idle();

        acc(1, 0, 3'b010, 32'h20, 32'h0, "sw20");
        acc(1, 0, 3'b000, 32'h21, 32'h0000_00AB, "sb21");
        acc(1, 0, 3'b001, 32'h22, 32'h0000_1234, "sh22");
        acc(0, 1, 3'b010, 32'h20, 32'h0, "lw20");
        chk("lw20.const", rdata, 32'h1234_AB00);

        acc(0, 1, 3'b010, 32'h22, 32'h0, "lw22mis");
        acc(1, 0, 3'b001, 32'h21, 32'h0000_FFFF, "sh21mis");
        acc(0, 1, 3'b011, 32'h20, 32'h0, "illop");
        acc(0, 1, 3'b010, 32'h20, 32'h0, "lw20again");
        chk("lw20again.const", rdata, 32'h1234_AB00);

        acc(1, 0, 3'b010, 32'h30, 32'h5A5A_5A5A, "sw30");
        acc(0, 1, 3'b010, 32'h30, 32'h0, "lw30");
        chk("lw30.const", rdata, 32'h5A5A_5A5A);
        acc(1, 1, 3'b010, 32'h30, 32'hA5A5_A5A5, "wr30");
        chk("wr30.held", rdata, 32'h5A5A_5A5A);
        acc(0, 1, 3'b010, 32'h30, 32'h0, "lw30b");
        chk("lw30b.const", rdata, 32'hA5A5_A5A5);

        for (int i = 0; i < 16; i++)
            acc(1, 0, 3'b010, 32'h100 + 32'(4 * i), $urandom, "fill");
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra = 32'h100 + 32'($urandom_range(0, 63));
            acc(1'($urandom), 1'($urandom), 3'($urandom), ra, $urandom, "rnd");
        end

`ifdef DMEM_MMIO_EN
        acc(1, 0, 3'b010, 32'hFFFF_0000, 32'h0001_BEEF, "ledw");
        chk("ledw.const", 32'(led), 32'h0000_BEEF);
        acc(0, 1, 3'b010, 32'hFFFF_0000, 32'h0, "ledr");
        acc(0, 1, 3'b010, 32'hFFFF_0004, 32'h0, "cnt1");
        c1 = rdata;
        idle();
        acc(0, 1, 3'b010, 32'hFFFF_0004, 32'h0, "cnt2");
        c2 = rdata;
        chk("cnt.diff", c2 - c1, 32'd2);
        acc(1, 0, 3'b000, 32'hFFFF_0000, 32'h0000_0011, "ledsb");
        chk("ledsb.const", 32'(led), 32'h0000_BEEF);
        acc(1, 0, 3'b010, 32'hFFFF_0004, 32'h1234_5678, "cntw");
        acc(0, 1, 3'b010, 32'hFFFF_0008, 32'h0, "ofs8");
`else
        c1 = '0; c2 = '0;
`endif

        // Reset in the middle of a load response, with a store held during reset.
        acc(0, 1, 3'b010, 32'h30, 32'h0, "prerst");
        #2 reset = 1'b0;
        #1;
        chk("arst.rdata", rdata, 32'h0);
        chk("arst.rvalid", 32'(rvalid), 32'h0);
        chk("arst.err", 32'(err), 32'h0);
        chk("arst.led", 32'(led), 32'h0);
        we = 1'b1; op = 3'b010; addr = 32'h30; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        we = 1'b0;
        chk("rst.hold", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rd_e = '0; led_m = '0;
        acc(0, 1, 3'b010, 32'h30, 32'h0, "postrst");
        chk("postrst.const", rdata, 32'hA5A5_A5A5);
`ifdef DMEM_MMIO_EN
        acc(0, 1, 3'b010, 32'hFFFF_0004, 32'h0, "cntrst");
        chk("cntrst.const", rdata, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
